checkout_change: RTL and testbench
==================================

Name: checkout_change

Overview:
- Payment stage directly downstream of the checkout totaliser.
- Accepts one finished transaction total, collects customer coins, and reports the remaining amount due.
- When the total is covered, dispenses change one coin per handshake using greedy denominations 50/10/5/1.
- Supports customer cancel with full refund, and keeps a running receipt counter of completed sales.

Parameters:
- SUM_W, 32: width of transaction total, due and internal change amounts.
- RCPT_W, 16: width of receipt counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- total_valid  in  1  a transaction total is presented.
- total  in  SUM_W  transaction total in $.
- total_ready  out  1  block can accept a total (high only in IDLE).
- coin_valid  in  1  one coin inserted this cycle.
- coin_sel  in  2  inserted coin: 0=$1, 1=$5, 2=$10, 3=$50.
- cancel  in  1  customer aborts; refund all paid coins.
- busy  out  1  high in any state other than IDLE.
- due  out  SUM_W  amount still owed; 0 outside COLLECT.
- chg_valid  out  1  a change/refund coin is offered.
- chg_coin  out  2  denomination offered, same encoding as coin_sel.
- chg_ack  in  1  dispenser took the offered coin.
- done  out  1  one-cycle pulse: sale completed.
- refunded  out  1  one-cycle pulse: transaction cancelled and refunded.
- receipt_no  out  RCPT_W  count of completed sales.

Behaviour:
- Reset (async, rst=1) forces the following; any transaction in progress is discarded.
  - State: IDLE.
  - Outputs: total_ready=1, busy=0, due=0, chg_valid=0, chg_coin=0, done=0, refunded=0, receipt_no=0.
  - Internal registers paid and chg_amt cleared.
- States: IDLE, COLLECT, CHANGE, DONE. All registered outputs update on rising clk.
- IDLE:
  - total_ready=1.
  - total_valid=1 with total==0: go to DONE as a sale.
  - total_valid=1 with total>0: latch total, set paid=0, go to COLLECT. due=total from the next cycle.
- COLLECT:
  - due = total - paid.
  - cancel=1 has priority over coin_valid; a coin presented in the same cycle is ignored.
    - cancel with paid>0: chg_amt=paid, set refund flag, go to CHANGE.
    - cancel with paid==0: go to DONE with the refund flag set.
  - coin_valid=1 with no cancel: p = paid + value(coin_sel), computed at SUM_W+1 bits so it cannot overflow.
    - p < total: paid=p, stay in COLLECT.
    - p == total: go to DONE as a sale.
    - p > total: chg_amt = p - total, go to CHANGE.
- CHANGE:
  - chg_valid=1.
  - chg_coin = largest denomination <= chg_amt, chosen from 50, 10, 5, 1.
  - chg_coin is held stable until chg_ack.
  - On chg_ack: chg_amt -= value(chg_coin). If the result is 0, go to DONE; otherwise re-evaluate the coin next cycle.
  - No back-to-back acks are required: at most one coin is accepted per cycle.
- DONE (one cycle):
  - Sale: done=1 and receipt_no increments, wrapping modulo 2^RCPT_W.
  - Refund: refunded=1 and receipt_no is unchanged.
  - Next state: IDLE.
- Input gating:
  - total_valid is ignored outside IDLE.
  - coin_valid and cancel are ignored outside COLLECT.
  - chg_ack is ignored while chg_valid=0.
- Latency:
  - Exact payment: the done pulse comes 1 cycle after the final coin edge.
  - Overpayment: CHANGE is entered 1 cycle after the final coin edge.

Test Plan:
1. total=37, then coin $50 → change coins 10,1,1,1 (four acks), then done=1 and receipt_no 0→1. due reads 37 throughout collection; due=0 in CHANGE.
2. total=63, coins 10×6 → due steps 53,43,33,23,13,3. Then coin $5 → change 1,1, then done.
3. total=40, coins 10, 5, then cancel → refund coins 10,5, then refunded=1, done=0, receipt_no unchanged.
4. total=0 → done pulse 1 cycle after acceptance, receipt_no +1, no chg_valid. Also: cancel with paid=0 → refunded pulse with no coins.
5. Overpay by 6, hold chg_ack low for 3 cycles → chg_coin stays 5 with chg_valid high; ack → coin 1 next. Assert rst mid-CHANGE → immediate IDLE and all outputs at reset values.
6. coin_valid=1 ($50) and cancel=1 in the same cycle with paid=5 → refund of exactly one $5, coin ignored. Also: total_valid pulsed during COLLECT → ignored, due unchanged.

Source files
------------

// File: rtl/checkout_change.sv
// Payment stage after the checkout totaliser: collects coins against a total,
// then pays out change or a full refund one coin per handshake (greedy 50/10/5/1).
module checkout_change #(
  parameter int SUM_W  = 32,
  parameter int RCPT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              total_valid,
  input  logic [SUM_W-1:0]  total,
  output logic              total_ready,
  input  logic              coin_valid,
  input  logic [1:0]        coin_sel,
  input  logic              cancel,
  output logic              busy,
  output logic [SUM_W-1:0]  due,
  output logic              chg_valid,
  output logic [1:0]        chg_coin,
  input  logic              chg_ack,
  output logic              done,
  output logic              refunded,
  output logic [RCPT_W-1:0] receipt_no
);

  typedef enum logic [1:0] {IDLE, COLLECT, CHANGE, DONE} state_t;

  state_t             state;
  logic [SUM_W-1:0]   total_r;
  logic [SUM_W-1:0]   paid;
  logic [SUM_W-1:0]   chg_amt;
  logic               refund_flag;

  logic [SUM_W:0]     pay_sum;
  logic [SUM_W-1:0]   over_amt;
  logic [SUM_W-1:0]   chg_rem;

  function automatic logic [SUM_W-1:0] coin_value(input logic [1:0] sel);
    logic [SUM_W-1:0] v;
    unique case (sel)
      2'd0:    v = SUM_W'(1);
      2'd1:    v = SUM_W'(5);
      2'd2:    v = SUM_W'(10);
      default: v = SUM_W'(50);
    endcase
    return v;
  endfunction

  function automatic logic [1:0] pick_coin(input logic [SUM_W-1:0] amt);
    logic [1:0] c;
    if (amt >= SUM_W'(50))      c = 2'd3;
    else if (amt >= SUM_W'(10)) c = 2'd2;
    else if (amt >= SUM_W'(5))  c = 2'd1;
    else                        c = 2'd0;
    return c;
  endfunction

  // One extra bit on the running sum so a large coin can never wrap past the total.
  assign pay_sum  = {1'b0, paid} + {1'b0, coin_value(coin_sel)};
  assign over_amt = pay_sum[SUM_W-1:0] - total_r;
  assign chg_rem  = chg_amt - coin_value(chg_coin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      total_r     <= '0;
      paid        <= '0;
      chg_amt     <= '0;
      refund_flag <= 1'b0;
      total_ready <= 1'b1;
      busy        <= 1'b0;
      due         <= '0;
      chg_valid   <= 1'b0;
      chg_coin    <= 2'd0;
      done        <= 1'b0;
      refunded    <= 1'b0;
      receipt_no  <= '0;
    end else begin
      done     <= 1'b0;
      refunded <= 1'b0;
      unique case (state)
        IDLE: begin
          if (total_valid) begin
            total_ready <= 1'b0;
            busy        <= 1'b1;
            paid        <= '0;
            refund_flag <= 1'b0;
            if (total == '0) begin
              state      <= DONE;
              done       <= 1'b1;
              receipt_no <= receipt_no + RCPT_W'(1);
            end else begin
              total_r <= total;
              due     <= total;
              state   <= COLLECT;
            end
          end
        end

        // Cancel wins over a coin presented in the same cycle.
        COLLECT: begin
          if (cancel) begin
            due         <= '0;
            refund_flag <= 1'b1;
            if (paid != '0) begin
              chg_amt   <= paid;
              chg_coin  <= pick_coin(paid);
              chg_valid <= 1'b1;
              state     <= CHANGE;
            end else begin
              refunded <= 1'b1;
              state    <= DONE;
            end
          end else if (coin_valid) begin
            if (pay_sum < {1'b0, total_r}) begin
              paid <= pay_sum[SUM_W-1:0];
              due  <= total_r - pay_sum[SUM_W-1:0];
            end else if (pay_sum == {1'b0, total_r}) begin
              due        <= '0;
              done       <= 1'b1;
              receipt_no <= receipt_no + RCPT_W'(1);
              state      <= DONE;
            end else begin
              due       <= '0;
              chg_amt   <= over_amt;
              chg_coin  <= pick_coin(over_amt);
              chg_valid <= 1'b1;
              state     <= CHANGE;
            end
          end
        end

        CHANGE: begin
          if (chg_ack && chg_valid) begin
            chg_amt <= chg_rem;
            if (chg_rem == '0) begin
              chg_valid <= 1'b0;
              chg_coin  <= 2'd0;
              state     <= DONE;
              if (refund_flag) begin
                refunded <= 1'b1;
              end else begin
                done       <= 1'b1;
                receipt_no <= receipt_no + RCPT_W'(1);
              end
            end else begin
              chg_coin <= pick_coin(chg_rem);
            end
          end
        end

        DONE: begin
          state       <= IDLE;
          total_ready <= 1'b1;
          busy        <= 1'b0;
          paid        <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_checkout_change.sv
// Scenario bench for checkout_change: expected change coins are queued as each
// payment is driven and popped as the dispenser acknowledges them.
module tb_checkout_change;
  localparam int SUM_W  = 32;
  localparam int RCPT_W = 16;

  logic              clk;
  logic              rst;
  logic              total_valid;
  logic [SUM_W-1:0]  total;
  logic              total_ready;
  logic              coin_valid;
  logic [1:0]        coin_sel;
  logic              cancel;
  logic              busy;
  logic [SUM_W-1:0]  due;
  logic              chg_valid;
  logic [1:0]        chg_coin;
  logic              chg_ack;
  logic              done;
  logic              refunded;
  logic [RCPT_W-1:0] receipt_no;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [1:0] exp_q[$];

  checkout_change #(.SUM_W(SUM_W), .RCPT_W(RCPT_W)) dut (
    .clk(clk), .rst(rst),
    .total_valid(total_valid), .total(total), .total_ready(total_ready),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .cancel(cancel),
    .busy(busy), .due(due),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .chg_ack(chg_ack),
    .done(done), .refunded(refunded), .receipt_no(receipt_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time exhausted");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_total(input logic [SUM_W-1:0] t);
    total_valid = 1'b1;
    total       = t;
    step();
    total_valid = 1'b0;
  endtask

  task automatic put_coin(input logic [1:0] sel);
    coin_valid = 1'b1;
    coin_sel   = sel;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    total_valid = 0; total = '0; coin_valid = 0; coin_sel = 0; cancel = 0; chg_ack = 0;
    step(); step();
    n_compared++;
    if ({total_ready, busy, chg_valid, chg_coin, done, refunded} !== 7'b1000000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 1000000",
               {total_ready, busy, chg_valid, chg_coin, done, refunded});
    end
    n_compared++;
    if (due !== '0 || receipt_no !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_regs: got due=%0d receipt=%0d expected 0/0", due, receipt_no);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_exact_change();
    logic [1:0] e;
    start_total(37);
    n_compared++;
    if (due !== 37 || busy !== 1'b1 || total_ready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL t1_accept: got due=%0d busy=%0b ready=%0b expected 37/1/0", due, busy, total_ready);
    end
    step(); step();
    n_compared++;
    if (due !== 37) begin
      n_mismatched++;
      $display("[TB] FAIL t1_due_hold: got %0d expected 37", due);
    end
    put_coin(2'd3);
    exp_q.push_back(2'd2); exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    n_compared++;
    if (due !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL t1_due_change: got %0d expected 0", due);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_compared++;
      if (chg_valid !== 1'b1 || chg_coin !== e) begin
        n_mismatched++;
        $display("[TB] FAIL t1_chg_coin: got valid=%0b coin=%0d expected valid=1 coin=%0d", chg_valid, chg_coin, e);
      end
      chg_ack = 1'b1; step(); chg_ack = 1'b0;
    end
    n_compared++;
    if (done !== 1'b1 || refunded !== 1'b0 || receipt_no !== 1 || chg_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL t1_done: got done=%0b ref=%0b rcpt=%0d cv=%0b expected 1/0/1/0", done, refunded, receipt_no, chg_valid);
    end
    step();
    n_compared++;
    if (done !== 1'b0 || total_ready !== 1'b1 || busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL t1_idle: got done=%0b ready=%0b busy=%0b expected 0/1/0", done, total_ready, busy);
    end
  endtask

  task automatic test_due_steps();
    logic [1:0] e;
    logic [SUM_W-1:0] exp_due;
    start_total(63);
    for (int i = 0; i < 6; i++) begin
      put_coin(2'd2);
      exp_due = SUM_W'(63 - 10 * (i + 1));
      n_compared++;
      if (due !== exp_due) begin
        n_mismatched++;
        $display("[TB] FAIL t2_due_step%0d: got %0d expected %0d", i, due, exp_due);
      end
    end
    put_coin(2'd1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_compared++;
      if (chg_valid !== 1'b1 || chg_coin !== e) begin
        n_mismatched++;
        $display("[TB] FAIL t2_chg_coin: got valid=%0b coin=%0d expected valid=1 coin=%0d", chg_valid, chg_coin, e);
      end
      chg_ack = 1'b1; step(); chg_ack = 1'b0;
    end
    n_compared++;
    if (done !== 1'b1 || receipt_no !== 2) begin
      n_mismatched++;
      $display("[TB] FAIL t2_done: got done=%0b rcpt=%0d expected 1/2", done, receipt_no);
    end
    step();
  endtask

  task automatic test_cancel_refund();
    logic [1:0] e;
    start_total(40);
    put_coin(2'd2);
    put_coin(2'd1);
    n_compared++;
    if (due !== 25) begin
      n_mismatched++;
      $display("[TB] FAIL t3_due: got %0d expected 25", due);
    end
    cancel = 1'b1; step(); cancel = 1'b0;
    exp_q.push_back(2'd2); exp_q.push_back(2'd1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_compared++;
      if (chg_valid !== 1'b1 || chg_coin !== e) begin
        n_mismatched++;
        $display("[TB] FAIL t3_refund_coin: got valid=%0b coin=%0d expected valid=1 coin=%0d", chg_valid, chg_coin, e);
      end
      chg_ack = 1'b1; step(); chg_ack = 1'b0;
    end
    n_compared++;
    if (refunded !== 1'b1 || done !== 1'b0 || receipt_no !== 2) begin
      n_mismatched++;
      $display("[TB] FAIL t3_refunded: got ref=%0b done=%0b rcpt=%0d expected 1/0/2", refunded, done, receipt_no);
    end
    step();
  endtask

  task automatic test_zero_and_empty_cancel();
    start_total(0);
    n_compared++;
    if (done !== 1'b1 || receipt_no !== 3 || chg_valid !== 1'b0 || refunded !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL t4_zero_total: got done=%0b rcpt=%0d cv=%0b ref=%0b expected 1/3/0/0", done, receipt_no, chg_valid, refunded);
    end
    step();
    n_compared++;
    if (done !== 1'b0 || total_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL t4_zero_idle: got done=%0b ready=%0b expected 0/1", done, total_ready);
    end
    start_total(12);
    cancel = 1'b1; step(); cancel = 1'b0;
    n_compared++;
    if (refunded !== 1'b1 || done !== 1'b0 || chg_valid !== 1'b0 || receipt_no !== 3) begin
      n_mismatched++;
      $display("[TB] FAIL t4_empty_cancel: got ref=%0b done=%0b cv=%0b rcpt=%0d expected 1/0/0/3", refunded, done, chg_valid, receipt_no);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    start_total(1);
    put_coin(2'd3);
    exp_q.push_back(2'd2); exp_q.push_back(2'd2); exp_q.push_back(2'd2); exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    chg_ack = 1'b1;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_compared++;
      if (chg_valid !== 1'b1 || chg_coin !== e) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_chg_coin: got valid=%0b coin=%0d expected valid=1 coin=%0d", chg_valid, chg_coin, e);
      end
      step();
    end
    chg_ack = 1'b0;
    n_compared++;
    if (done !== 1'b1 || receipt_no !== 4 || chg_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_done: got done=%0b rcpt=%0d cv=%0b expected 1/4/0", done, receipt_no, chg_valid);
    end
    step();
  endtask

  task automatic test_hold_and_reset();
    start_total(4);
    put_coin(2'd2);
    for (int i = 0; i < 3; i++) begin
      n_compared++;
      if (chg_valid !== 1'b1 || chg_coin !== 2'd1) begin
        n_mismatched++;
        $display("[TB] FAIL t5_hold%0d: got valid=%0b coin=%0d expected valid=1 coin=1", i, chg_valid, chg_coin);
      end
      step();
    end
    chg_ack = 1'b1; step(); chg_ack = 1'b0;
    n_compared++;
    if (chg_valid !== 1'b1 || chg_coin !== 2'd0) begin
      n_mismatched++;
      $display("[TB] FAIL t5_next_coin: got valid=%0b coin=%0d expected valid=1 coin=0", chg_valid, chg_coin);
    end
    rst = 1'b1;
    #2;
    n_compared++;
    if ({total_ready, busy, chg_valid, chg_coin, done, refunded} !== 7'b1000000 || due !== '0 || receipt_no !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL t5_async_reset: got flags=%b due=%0d rcpt=%0d expected 1000000/0/0",
               {total_ready, busy, chg_valid, chg_coin, done, refunded}, due, receipt_no);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_cancel_priority();
    logic [1:0] e;
    start_total(20);
    put_coin(2'd1);
    total_valid = 1'b1; total = 99; step(); total_valid = 1'b0;
    n_compared++;
    if (due !== 15 || total_ready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL t6_total_ignored: got due=%0d ready=%0b expected 15/0", due, total_ready);
    end
    coin_valid = 1'b1; coin_sel = 2'd3; cancel = 1'b1;
    step();
    coin_valid = 1'b0; cancel = 1'b0;
    exp_q.push_back(2'd1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_compared++;
      if (chg_valid !== 1'b1 || chg_coin !== e) begin
        n_mismatched++;
        $display("[TB] FAIL t6_refund_coin: got valid=%0b coin=%0d expected valid=1 coin=%0d", chg_valid, chg_coin, e);
      end
      chg_ack = 1'b1; step(); chg_ack = 1'b0;
    end
    n_compared++;
    if (refunded !== 1'b1 || done !== 1'b0 || chg_valid !== 1'b0 || receipt_no !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL t6_refunded: got ref=%0b done=%0b cv=%0b rcpt=%0d expected 1/0/0/0", refunded, done, chg_valid, receipt_no);
    end
    step();
    n_compared++;
    if (total_ready !== 1'b1 || busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL t6_idle: got ready=%0b busy=%0b expected 1/0", total_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_exact_change();
    test_due_steps();
    test_cancel_refund();
    test_zero_and_empty_cancel();
    test_back_to_back();
    test_hold_and_reset();
    test_cancel_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
